// File: rtl/jtframe_info_pkg.sv
// Shared constants for the system-info snapshot scanner: address table, FSM states, limits.
package jtframe_info_pkg;

   localparam int WAIT_MAX  = 7;
   localparam int TABLE_LEN = 16;
   localparam int CNT_W     = $clog2(WAIT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET,
      ST_WAIT,
      ST_CAPT,
      ST_SWAP
   } info_state_t;

   // Entry 0 is the rightmost byte: SDRAM stats 00..0B, frame counter LSB/MSB, sample rate, reserved.
   localparam logic [TABLE_LEN-1:0][7:0] SCAN_TABLE = {
      8'hFF, 8'h80, 8'h41, 8'h40,
      8'h0B, 8'h0A, 8'h09, 8'h08,
      8'h07, 8'h06, 8'h05, 8'h04,
      8'h03, 8'h02, 8'h01, 8'h00
   };

endpackage

// File: rtl/jtframe_info_dbuf.sv
// Front/back snapshot buffers; writes go to the back, reads come from the front, swap flips roles.
module jtframe_info_dbuf
   import jtframe_info_pkg::*;
#(
   parameter int ENTRIES = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [3:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       swap,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem_a [TABLE_LEN];
   logic [7:0] mem_b [TABLE_LEN];
   logic       front_b;
   logic       front_nx;

   // Reading through the post-swap selection makes new data visible right after the swap cycle.
   assign front_nx = front_b ^ swap;

   always_ff @(posedge clk) begin
      if (rst) begin
         front_b <= 1'b0;
         rd_data <= 8'd0;
         for (int i = 0; i < TABLE_LEN; i++) begin
            mem_a[i] <= 8'd0;
            mem_b[i] <= 8'd0;
         end
      end else begin
         front_b <= front_nx;
         if (we) begin
            if (front_b) mem_a[wr_addr] <= wr_data;
            else         mem_b[wr_addr] <= wr_data;
         end
         if (int'(rd_addr) >= ENTRIES) rd_data <= 8'd0;
         else if (front_nx)            rd_data <= mem_b[rd_addr];
         else                          rd_data <= mem_a[rd_addr];
      end
   end

endmodule

// File: rtl/jtframe_info_scan.sv
// Sweeps SCAN_TABLE addresses into a double-buffered snapshot on request.
// Optional JTFRAME_INFO_AUTOSCAN_EN: also request a sweep at every LVBL falling edge.
//
// state   | meaning
// IDLE    | waiting for a request, st_addr holds last value
// SET     | drive st_addr from the table, load wait counter
// WAIT    | let the info block settle its registered output
// CAPT    | store st_din into the back buffer, advance index
// SWAP    | exchange buffers, pulse done
module jtframe_info_scan
   import jtframe_info_pkg::*;
#(
   parameter int WAIT    = 2,
   parameter int ENTRIES = 16
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       scan,
   input  logic       LVBL,
   output logic [7:0] st_addr,
   input  logic [7:0] st_din,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done
);

   info_state_t      state, state_nx;
   logic [3:0]       idx, idx_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [7:0]       addr_nx;
   logic             pending, pending_nx;
   logic             scan_q;
   logic             req;
   logic             start;
   logic             we;
   logic             swap;

`ifdef JTFRAME_INFO_AUTOSCAN_EN
   logic lvbl_q;

   always_ff @(posedge clk) begin
      if (rst) lvbl_q <= 1'b0;
      else     lvbl_q <= LVBL;
   end

   assign req = (scan & ~scan_q) | (lvbl_q & ~LVBL);
`else
   logic unused_lvbl;

   assign unused_lvbl = LVBL;
   assign req         = scan & ~scan_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         idx     <= 4'd0;
         cnt     <= '0;
         pending <= 1'b0;
         st_addr <= 8'd0;
         scan_q  <= 1'b1;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         cnt     <= cnt_nx;
         pending <= pending_nx;
         st_addr <= addr_nx;
         scan_q  <= scan;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      cnt_nx   = cnt;
      addr_nx  = st_addr;
      start    = 1'b0;
      we       = 1'b0;
      swap     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pending || req) begin
               start    = 1'b1;
               idx_nx   = 4'd0;
               state_nx = ST_SET;
            end
         end
         ST_SET: begin
            addr_nx  = SCAN_TABLE[idx];
            cnt_nx   = CNT_W'(WAIT - 1);
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt == '0) state_nx = ST_CAPT;
            else           cnt_nx   = cnt - 1'b1;
         end
         ST_CAPT: begin
            we = 1'b1;
            if (idx == 4'(ENTRIES - 1)) begin
               state_nx = ST_SWAP;
            end else begin
               idx_nx   = idx + 4'd1;
               state_nx = ST_SET;
            end
         end
         ST_SWAP: begin
            swap = 1'b1;
            // Back-to-back sweep: a queued or coincident request skips IDLE entirely.
            if (pending || req) begin
               start    = 1'b1;
               idx_nx   = 4'd0;
               state_nx = ST_SET;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      if (start)    pending_nx = 1'b0;
      else if (req) pending_nx = 1'b1;
      else          pending_nx = pending;
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_SWAP);

   jtframe_info_dbuf #(
      .ENTRIES (ENTRIES)
   ) u_dbuf (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (idx),
      .wr_data (st_din),
      .swap    (swap),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

endmodule
